// File: rtl/flit_pkg.sv
// Shared flit types, field positions and injection state encoding for the
// deflection-router local injection controller.
package flit_pkg;

  localparam int FLIT_W   = 10;
  localparam int PRIO_BIT = 9;
  localparam int PORT_MSB = 8;
  localparam int PORT_LSB = 6;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    STARVED = 2'd2
  } inj_state_e;

  // Promote a flit to high priority without touching port code or payload.
  function automatic flit_t golden_flit(input flit_t f);
    flit_t r;
    r           = f;
    r[PRIO_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/inject_fifo.sv
// DEPTH-entry synchronous FIFO holding core flits awaiting injection.
// Head is read combinationally so a flit written at edge N is visible at N+1.
module inject_fifo
  import flit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  flit_t                    push_flit,
  input  logic                     pop,
  output flit_t                    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  flit_t         mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO refuses pushes even when a pop frees an entry this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_flit;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/flit_inject_ctrl.sv
// Local injection controller: queues core flits, injects the head into the
// lowest free router slot, and flags starvation. FLIT_GOLDEN_EN promotes starved flits.
module flit_inject_ctrl
  import flit_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int NSLOT        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FLIT_W-1:0]         in_flit,
  input  logic [NSLOT-1:0]          slot_valid_i,
  input  logic [NSLOT*FLIT_W-1:0]   slot_flit_i,
  output logic [NSLOT-1:0]          slot_valid_o,
  output logic [NSLOT*FLIT_W-1:0]   slot_flit_o,
  output logic                      throttle,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  flit_t                    fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_cnt;
  logic                     push_ok;
  logic                     any_free;
  logic                     inject;
  logic                     found;
  logic [NSLOT-1:0]         sel_onehot;
  flit_t                    inj_flit;

  inj_state_e               state_q, state_d;
  logic [SW-1:0]            cnt_q, cnt_d;
  logic                     throttle_q, throttle_d;
  logic [NSLOT-1:0]         slot_valid_q, slot_valid_d;
  logic [NSLOT*FLIT_W-1:0]  slot_flit_q, slot_flit_d;

  assign in_ready = !fifo_full;
  assign push_ok  = in_valid && in_ready;
  assign any_free = ~&slot_valid_i;
  assign inject   = !fifo_empty && any_free;

  inject_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_flit (in_flit),
    .pop       (inject),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Lowest-indexed empty slot wins.
  always_comb begin
    sel_onehot = '0;
    found      = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      if (!slot_valid_i[k] && !found) begin
        sel_onehot[k] = 1'b1;
        found         = 1'b1;
      end
    end
  end

`ifdef FLIT_GOLDEN_EN
  assign inj_flit = (state_q == STARVED) ? golden_flit(fifo_head) : fifo_head;
`else
  assign inj_flit = fifo_head;
`endif

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    logic take;
    assign take = inject && sel_onehot[gi];
    assign slot_valid_d[gi] = slot_valid_i[gi] || take;
    assign slot_flit_d[gi*FLIT_W +: FLIT_W] =
        slot_valid_i[gi] ? slot_flit_i[gi*FLIT_W +: FLIT_W] :
        take             ? inj_flit : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = push_ok ? WAIT : IDLE;
      end
      WAIT, STARVED: begin
        if (inject) begin
          cnt_d   = '0;
          // Only the last queued flit leaving without a refill empties the FIFO.
          state_d = (fifo_cnt == CW'(1) && !push_ok) ? IDLE : WAIT;
        end else begin
          if (cnt_q != SW'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + SW'(1);
          end
          state_d = (cnt_d == SW'(STARVE_LIMIT)) ? STARVED : WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    throttle_d = (state_d == STARVED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      throttle_q   <= 1'b0;
      slot_valid_q <= '0;
      slot_flit_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      throttle_q   <= throttle_d;
      slot_valid_q <= slot_valid_d;
      slot_flit_q  <= slot_flit_d;
    end
  end

  assign slot_valid_o = slot_valid_q;
  assign slot_flit_o  = slot_flit_q;
  assign throttle     = throttle_q;
  assign fifo_count   = fifo_cnt;

endmodule

// File: tb/tb_flit_inject_ctrl.sv
// Scoreboard bench for flit_inject_ctrl: a queue-based reference model pushes
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_flit_inject_ctrl;

  localparam int DEPTH = 4;
  localparam int NSLOT = 4;
  localparam int LIMIT = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FLIT_GOLDEN_EN
  localparam logic [9:0] GOLD_EXP = 10'h23F;
`else
  localparam logic [9:0] GOLD_EXP = 10'h03F;
`endif
  localparam logic [NSLOT*10-1:0] PAT = 40'hA5_5A3C_C3F0;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [9:0]            in_flit = '0;
  logic [NSLOT-1:0]      slot_valid_i = '0;
  logic [NSLOT*10-1:0]   slot_flit_i = '0;
  logic [NSLOT-1:0]      slot_valid_o;
  logic [NSLOT*10-1:0]   slot_flit_o;
  logic                  throttle;
  logic [CW-1:0]         fifo_count;

  typedef struct {
    logic [NSLOT-1:0]    v;
    logic [NSLOT*10-1:0] f;
    int                  cnt;
    logic                thr;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] m_q[$];
  int         m_cnt;
  bit         m_starved;
  int         n_vec;
  int         n_bad;

  always #5 clk = ~clk;

  flit_inject_ctrl #(
    .DEPTH        (DEPTH),
    .NSLOT        (NSLOT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flit      (in_flit),
    .slot_valid_i (slot_valid_i),
    .slot_flit_i  (slot_flit_i),
    .slot_valid_o (slot_valid_o),
    .slot_flit_o  (slot_flit_o),
    .throttle     (throttle),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_flit      = '0;
    slot_valid_i = '0;
    slot_flit_i  = '0;
    @(posedge clk); #1;
    check("rst_slot_valid", 64'(slot_valid_o), 64'd0);
    check("rst_slot_flit",  64'(slot_flit_o),  64'd0);
    check("rst_throttle",   64'(throttle),     64'd0);
    check("rst_count",      64'(fifo_count),   64'd0);
    check("rst_in_ready",   64'(in_ready),     64'd1);
    $display("reset: count=%0d thr=%0b", fifo_count, throttle);
    rst = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_cnt     = 0;
    m_starved = 0;
  endtask

  task automatic step(input logic v, input logic [9:0] f,
                      input logic [NSLOT-1:0] sv, input logic [NSLOT*10-1:0] sf);
    exp_t       e;
    exp_t       got;
    int         sel;
    bit         inj;
    bit         rdy;
    logic [9:0] iflit;
    in_valid     = v;
    in_flit      = f;
    slot_valid_i = sv;
    slot_flit_i  = sf;
    rdy = (m_q.size() != DEPTH);
    check("in_ready", 64'(in_ready), 64'(rdy));
    sel = -1;
    for (int k = 0; k < NSLOT; k++) begin
      if (!sv[k] && sel < 0) sel = k;
    end
    inj = (m_q.size() > 0) && (sel >= 0);
    e.v = sv;
    e.f = sf;
    for (int k = 0; k < NSLOT; k++) begin
      if (!sv[k]) e.f[k*10 +: 10] = '0;
    end
    if (inj) begin
      iflit = m_q[0];
`ifdef FLIT_GOLDEN_EN
      if (m_starved) iflit[9] = 1'b1;
`endif
      e.v[sel]          = 1'b1;
      e.f[sel*10 +: 10] = iflit;
      void'(m_q.pop_front());
      m_cnt = 0;
    end else if (m_q.size() > 0) begin
      if (m_cnt < LIMIT) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    if (v && rdy) m_q.push_back(f);
    m_starved = (m_cnt == LIMIT);
    e.cnt = m_q.size();
    e.thr = m_starved;
    exp_q.push_back(e);

    @(posedge clk); #1;
    got.v = slot_valid_o;
    got.f = slot_flit_o;
    got.cnt = int'(fifo_count);
    got.thr = throttle;
    e = exp_q.pop_front();
    check("slot_valid", 64'(got.v), 64'(e.v));
    check("slot_flit",  64'(got.f), 64'(e.f));
    check("fifo_count", 64'(got.cnt), 64'(e.cnt));
    check("throttle",   64'(got.thr), 64'(e.thr));
    $display("txn: in_v=%0b in=%03h sv=%b -> sv_o=%b cnt=%0d thr=%0b",
             v, f, sv, slot_valid_o, fifo_count, throttle);
  endtask

  initial begin
    logic [63:0] r64;
    n_vec = 0;
    n_bad = 0;
    m_cnt = 0;
    m_starved = 0;

    do_reset();

    // First push then inject into slot 0
    step(1'b1, 10'h155, 4'b0000, '0);
    check("push_count", 64'(fifo_count), 64'd1);
    step(1'b0, 10'h000, 4'b0000, '0);
    check("inj0_valid", 64'(slot_valid_o), 64'h1);
    check("inj0_flit",  64'(slot_flit_o[9:0]), 64'h155);

    // Lowest free slot is 2
    step(1'b1, 10'h0AA, 4'b1111, PAT);
    step(1'b0, 10'h000, 4'b1011, PAT);
    check("slot2_flit",  64'(slot_flit_o[29:20]), 64'h0AA);
    check("slot2_valid", 64'(slot_valid_o), 64'hF);

    // Fill FIFO, then push against full while popping
    for (int i = 0; i < DEPTH; i++) step(1'b1, 10'(10'h100 + i), 4'b1111, PAT);
    check("full_count", 64'(fifo_count), 64'(DEPTH));
    check("full_ready", 64'(in_ready), 64'd0);
    step(1'b1, 10'h3FF, 4'b1110, PAT);
    check("full_pushpop", 64'(fifo_count), 64'(DEPTH - 1));

    // Starve and drain
    repeat (10) step(1'b0, 10'h000, 4'b1111, PAT);
    repeat (3) step(1'b0, 10'h000, 4'b1110, PAT);

    // Starvation boundary and golden promotion
    do_reset();
    step(1'b1, 10'h03F, 4'b1111, PAT);
    repeat (LIMIT - 1) step(1'b0, 10'h000, 4'b1111, PAT);
    check("pre_starve_thr", 64'(throttle), 64'd0);
    step(1'b0, 10'h000, 4'b1111, PAT);
    check("starve_thr", 64'(throttle), 64'd1);
    step(1'b0, 10'h000, 4'b1110, PAT);
    check("golden_flit", 64'(slot_flit_o[9:0]), 64'(GOLD_EXP));
    check("release_thr", 64'(throttle), 64'd0);

    // Mid-operation reset with queued flits and busy slot outputs
    step(1'b1, 10'h011, 4'b1111, PAT);
    step(1'b1, 10'h022, 4'b1111, PAT);
    step(1'b1, 10'h033, 4'b1111, PAT);
    check("pre_rst_count", 64'(fifo_count), 64'd3);
    do_reset();

    // Random traffic, biased toward full slots to exercise starvation
    for (int i = 0; i < 300; i++) begin
      logic [NSLOT-1:0] sv;
      r64 = {$urandom(), $urandom()};
      sv  = ($urandom_range(0, 3) == 0) ? NSLOT'($urandom()) : '1;
      step(1'($urandom_range(0, 1)), 10'($urandom()), sv, r64[NSLOT*10-1:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
